// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
// Brings up the board PLL from the free-running reference clock. It pulses the
// PLL RESET, waits for LOCK with a timeout and a bounded number of retries, and
// requires LOCK to stay high for a qualification window. Only then does it
// release the downstream system reset. A loss of lock while running starts the
// whole sequence again.
//
// Optional feature macro: PLL_PWD_EN (adds the PWRDN state driven by pwr_down_i)
//
// Ports
//   clk          free-running reference clock (same net as PLL clkin)
//   rst_n        asynchronous active-low reset
//   pll_lock_i   PLL LOCK, asynchronous to clk (synchronised internally)
//   restart_i    one-cycle pulse: abort and restart acquisition
//   pwr_down_i   PLL power-down request (used only with PLL_PWD_EN)
//   pll_reset_o  PLL RESET
//   pll_pwd_o    PLL PLLPWD (constant 0 without PLL_PWD_EN)
//   sys_rst_n_o  downstream reset, active low
//   locked_o     qualified lock
//   fault_o      retries exhausted
//   retry_cnt_o  timed-out attempts in the current acquisition
//   loss_cnt_o   lock losses while running, saturating at 255
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock_i,
  input  logic       restart_i,
  input  logic       pwr_down_i,
  output logic       pll_reset_o,
  output logic       pll_pwd_o,
  output logic       sys_rst_n_o,
  output logic       locked_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] loss_cnt_o
);

  // The counter only ever needs to reach (largest parameter - 1).
  localparam int MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES
                                                                 : LOCK_STABLE_CYCLES;
  localparam int MAX_P = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W = (MAX_P < 2) ? 1 : $clog2(MAX_P);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4,
    ST_PWRDN  = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_clr_s;
  logic [3:0]       retry_r;
  logic [3:0]       retry_nxt_s;
  logic [7:0]       loss_r;
  logic [7:0]       loss_nxt_s;
  logic             lock_meta_r;
  logic             lock_sync_r;
  logic             pwd_req_s;
  logic             pll_reset_r;
  logic             sys_rst_n_r;
  logic             locked_r;
  logic             fault_r;

`ifdef PLL_PWD_EN
  logic             pll_pwd_r;

  assign pwd_req_s = pwr_down_i;
`else
  logic             unused_pwr_down_s;

  assign pwd_req_s         = 1'b0;
  assign unused_pwr_down_s = pwr_down_i;
`endif

  // Two-flop synchroniser for the asynchronous PLL LOCK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_lock_i;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Next-state and counter-update decisions; power-down beats restart, restart beats the rest.
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_r;
    loss_nxt_s  = loss_r;
    cnt_clr_s   = 1'b0;
    if (pwd_req_s) begin
      state_nxt_s = ST_PWRDN;
    end else if (restart_i) begin
      // Clearing the counter as well keeps the pulse counter at 0 while restart is held.
      state_nxt_s = ST_RST;
      retry_nxt_s = 4'd0;
      cnt_clr_s   = 1'b1;
    end else begin
      case (state_r)
        ST_RST: begin
          if (cnt_r == RST_LAST) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_RST;
          end
        end
        ST_WAIT: begin
          if (lock_sync_r) begin
            state_nxt_s = ST_STABLE;
          end else if (cnt_r == TMO_LAST) begin
            if (retry_r == RETRY_LIMIT) begin
              state_nxt_s = ST_FAULT;
            end else begin
              state_nxt_s = ST_RST;
              retry_nxt_s = retry_r + 4'd1;
            end
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_STABLE: begin
          // Dropping back to WAIT restarts the timeout without consuming a retry.
          if (!lock_sync_r) begin
            state_nxt_s = ST_WAIT;
          end else if (cnt_r == STB_LAST) begin
            state_nxt_s = ST_RUN;
            retry_nxt_s = 4'd0;
          end else begin
            state_nxt_s = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!lock_sync_r) begin
            state_nxt_s = ST_RST;
            if (loss_r != 8'hFF) begin
              loss_nxt_s = loss_r + 8'd1;
            end else begin
              loss_nxt_s = loss_r;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        ST_PWRDN: begin
          // Reaching here means the power-down request has been released.
          state_nxt_s = ST_RST;
          retry_nxt_s = 4'd0;
        end
        default: begin
          state_nxt_s = ST_RST;
        end
      endcase
    end
  end

  // State, retry and loss registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RST;
      retry_r <= 4'd0;
      loss_r  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      retry_r <= retry_nxt_s;
      loss_r  <= loss_nxt_s;
    end
  end

  // Shared cycle counter: zero on entry to every state, saturates rather than wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_nxt_s != state_r) || cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset_r <= 1'b1;
      sys_rst_n_r <= 1'b0;
      locked_r    <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      pll_reset_r <= (state_nxt_s == ST_RST) || (state_nxt_s == ST_FAULT) ||
                     (state_nxt_s == ST_PWRDN);
      sys_rst_n_r <= (state_nxt_s == ST_RUN);
      locked_r    <= (state_nxt_s == ST_RUN);
      fault_r     <= (state_nxt_s == ST_FAULT);
    end
  end

`ifdef PLL_PWD_EN
  // PLL power-down output, high only while in PWRDN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_pwd_r <= 1'b0;
    end else begin
      pll_pwd_r <= (state_nxt_s == ST_PWRDN);
    end
  end

  assign pll_pwd_o = pll_pwd_r;
`else
  assign pll_pwd_o = 1'b0;
`endif

  assign pll_reset_o = pll_reset_r;
  assign sys_rst_n_o = sys_rst_n_r;
  assign locked_o    = locked_r;
  assign fault_o     = fault_r;
  assign retry_cnt_o = retry_r;
  assign loss_cnt_o  = loss_r;

endmodule
